// File: rtl/sd_rom_arbiter.sv
// Two-port read arbiter in front of a paged SD ROM. It grants one requester
// at a time, drives the ROM address/enable, and waits out the ROM settle
// time. It then waits for the ROM to report not-busy, or gives up after a
// bounded number of cycles and returns 8'hff with a sticky error flag.
module sd_rom_arbiter #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned PRIORITY_MODE  = 0,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [23:0] addr0,
  output logic        ack0,
  input  logic        req1,
  input  logic [23:0] addr1,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic [23:0] sd_address,
  output logic        sd_enable,
  input  logic        sd_busy,
  input  logic [7:0]  sd_data,
  output logic        timeout_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam bit         FIXED_PRIO  = (PRIORITY_MODE == 1);

  logic [1:0]  r_state;
  logic [3:0]  r_settle;
  logic [23:0] r_wait;
  logic        r_grant;
  logic        r_lastGrant;
  logic [23:0] r_sdAddress;
  logic        r_sdEnable;
  logic        r_ack0;
  logic        r_ack1;
  logic [7:0]  r_rdata;
  logic        r_timeoutErr;

  logic        w_anyReq;
  logic        w_pick1;
  logic        w_grant;
  logic        w_settleDone;
  logic [23:0] w_waitNext;
  logic        w_hit;
  logic        w_timeout;
  logic        w_done;

  // A requester still holds req during its ack cycle, so no new grant is
  // made while an ack is out; this gives the IDLE re-arbitration cycle.
  // lastGrant = 1 means port 1 was served last, so port 0 wins the next tie.
  always_comb begin
    w_anyReq     = req0 | req1;
    if (FIXED_PRIO) begin
      w_pick1 = req1 & ~req0;
    end else begin
      w_pick1 = req1 & (~req0 | ~r_lastGrant);
    end
    w_grant      = (r_state == ST_IDLE) & w_anyReq & ~r_ack0 & ~r_ack1;
    w_settleDone = (r_state == ST_SETTLE) & (r_settle == 4'd1);
    w_waitNext   = r_wait + 24'd1;
    w_hit        = (r_state == ST_WAIT) & ~sd_busy;
    w_timeout    = (r_state == ST_WAIT) & sd_busy & (w_waitNext == TIMEOUT_CYCLES);
    w_done       = w_hit | w_timeout;
  end

  // Main sequencing: IDLE -> SETTLE -> WAIT -> IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_grant)      r_state <= ST_SETTLE;
        ST_SETTLE: if (w_settleDone) r_state <= ST_WAIT;
        ST_WAIT:   if (w_done)       r_state <= ST_IDLE;
        default:                     r_state <= ST_IDLE;
      endcase
    end
  end

  // Settle countdown after each new address, and busy-cycle count inside WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_settle <= 4'd0;
      r_wait   <= 24'd0;
    end else begin
      if (w_grant) begin
        r_settle <= SETTLE_LOAD;
      end else if (r_state == ST_SETTLE) begin
        r_settle <= r_settle - 4'd1;
      end
      if (w_settleDone) begin
        r_wait <= 24'd0;
      end else if ((r_state == ST_WAIT) && sd_busy) begin
        r_wait <= w_waitNext;
      end
    end
  end

  // Grant bookkeeping and the ROM-side address/enable; the address holds
  // its last value between transactions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_sdAddress <= 24'd0;
      r_sdEnable  <= 1'b0;
    end else if (w_grant) begin
      r_grant     <= w_pick1;
      r_lastGrant <= w_pick1;
      r_sdAddress <= w_pick1 ? addr1 : addr0;
      r_sdEnable  <= 1'b1;
    end else if (w_done) begin
      r_sdEnable  <= 1'b0;
    end
  end

  // Completion: one-cycle ack to the winner, read data capture, and the
  // sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata      <= 8'd0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_ack0 <= w_done & ~r_grant;
      r_ack1 <= w_done & r_grant;
      if (w_hit) begin
        r_rdata <= sd_data;
      end else if (w_timeout) begin
        r_rdata      <= 8'hff;
        r_timeoutErr <= 1'b1;
      end
    end
  end

  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign rdata       = r_rdata;
  assign sd_address  = r_sdAddress;
  assign sd_enable   = r_sdEnable;
  assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_sd_rom_arbiter.sv
// Bench for sd_rom_arbiter. Instance A uses the round-robin defaults and
// instance B uses fixed priority with a short timeout. Both share the
// stimulus. Completions are checked against a per-instance scoreboard.
module tb_sd_rom_arbiter;

  typedef struct {
    bit          port;
    logic [7:0]  rdata;
    bit          tmo;
  } sbItem_t;

  typedef struct {
    bit          port;
    logic [23:0] addr;
    logic [7:0]  data;
    int          busyCyc;
    int          expLat;
  } vector_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic        sd_busy = 1'b0;
  logic [7:0]  sd_data = '0;

  logic        ackA0, ackA1, sdEnableA, timeoutA;
  logic [7:0]  rdataA;
  logic [23:0] sdAddrA;
  logic        ackB0, ackB1, sdEnableB, timeoutB;
  logic [7:0]  rdataB;
  logic [23:0] sdAddrB;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit enA = 1'b0, enB = 1'b0;
  sbItem_t qA[$];
  sbItem_t qB[$];
  sbItem_t eA, eB;

  sd_rom_arbiter #(.SETTLE_CYCLES(2), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(24'd12000000)) dutA (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .ack0(ackA0),
    .req1(req1), .addr1(addr1), .ack1(ackA1),
    .rdata(rdataA), .sd_address(sdAddrA), .sd_enable(sdEnableA),
    .sd_busy(sd_busy), .sd_data(sd_data), .timeout_err(timeoutA)
  );

  sd_rom_arbiter #(.SETTLE_CYCLES(2), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(24'd16)) dutB (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .ack0(ackB0),
    .req1(req1), .addr1(addr1), .ack1(ackB1),
    .rdata(rdataB), .sd_address(sdAddrB), .sd_enable(sdEnableB),
    .sd_busy(sd_busy), .sd_data(sd_data), .timeout_err(timeoutB)
  );

  always #5 clk = ~clk;

  // Cycle index: value seen at a falling edge is the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: every ack pops the oldest expected completion.
  always @(negedge clk) begin
    if (reset && enA && (ackA0 || ackA1)) begin
      checkOutput("ackExclusiveA", 32'(ackA0 & ackA1), 32'd0);
      if (qA.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedAckA: got ack0=%0b ack1=%0b, expected none (cycle %0d)", ackA0, ackA1, cyc);
      end else begin
        eA = qA.pop_front();
        checkOutput("ackPortA", 32'(ackA1), 32'(eA.port));
        checkOutput("rdataA", 32'(rdataA), 32'(eA.rdata));
        checkOutput("timeoutErrA", 32'(timeoutA), 32'(eA.tmo));
      end
    end
    if (reset && enB && (ackB0 || ackB1)) begin
      checkOutput("ackExclusiveB", 32'(ackB0 & ackB1), 32'd0);
      if (qB.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedAckB: got ack0=%0b ack1=%0b, expected none (cycle %0d)", ackB0, ackB1, cyc);
      end else begin
        eB = qB.pop_front();
        checkOutput("ackPortB", 32'(ackB1), 32'(eB.port));
        checkOutput("rdataB", 32'(rdataB), 32'(eB.rdata));
        checkOutput("timeoutErrB", 32'(timeoutB), 32'(eB.tmo));
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    checkOutput("queueDrained", 32'(qA.size() + qB.size()), 32'd0);
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    sd_busy = 1'b0;
    enA = 1'b0;
    enB = 1'b0;
    repeat (2) @(negedge clk);
    qA.delete();
    qB.delete();
    reset = 1'b1;
  endtask

  // One single-requester transaction; sd_busy is held high through SETTLE
  // and for busyCyc WAIT cycles, then released.
  task automatic applyStimulus(input bit useB, input bit port, input logic [23:0] addr,
                               input logic [7:0] data, input int busyCyc, input int expLat);
    int k;
    bit seen;
    @(negedge clk);
    k = cyc;
    if (port) begin addr1 = addr; req1 = 1'b1; end
    else      begin addr0 = addr; req0 = 1'b1; end
    sd_data = data;
    sd_busy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (cyc >= k + 3 + busyCyc) sd_busy = 1'b0;
      if (useB ? (ackB0 | ackB1) : (ackA0 | ackA1)) seen = 1'b1;
    end
    checkOutput("ackSeen", 32'(seen), 32'd1);
    if (seen) begin
      checkOutput("latency", 32'(cyc - k), 32'(expLat));
      checkOutput("sdAddress", 32'(useB ? sdAddrB : sdAddrA), 32'(addr));
    end
    req0 = 1'b0;
    req1 = 1'b0;
    sd_busy = 1'b0;
  endtask

  vector_t vecs[6];

  initial begin
    int acks[4];
    int n;
    int enableDrops;

    vecs[0] = '{port: 1'b0, addr: 24'h00c010, data: 8'h5a, busyCyc: 0,  expLat: 4};
    vecs[1] = '{port: 1'b1, addr: 24'h123456, data: 8'ha5, busyCyc: 0,  expLat: 4};
    vecs[2] = '{port: 1'b0, addr: 24'hffffff, data: 8'h00, busyCyc: 3,  expLat: 7};
    vecs[3] = '{port: 1'b1, addr: 24'h000000, data: 8'hff, busyCyc: 1,  expLat: 5};
    vecs[4] = '{port: 1'b0, addr: 24'h800001, data: 8'h3c, busyCyc: 10, expLat: 14};
    vecs[5] = '{port: 1'b1, addr: 24'h7fffff, data: 8'h81, busyCyc: 0,  expLat: 4};

    // Reset state of instance A.
    doReset();
    @(negedge clk);
    checkOutput("resetAck0", 32'(ackA0), 32'd0);
    checkOutput("resetAck1", 32'(ackA1), 32'd0);
    checkOutput("resetSdEnable", 32'(sdEnableA), 32'd0);
    checkOutput("resetSdAddress", 32'(sdAddrA), 32'd0);
    checkOutput("resetRdata", 32'(rdataA), 32'd0);
    checkOutput("resetTimeoutErr", 32'(timeoutA), 32'd0);

    // Table-driven single transactions on instance A.
    enA = 1'b1;
    for (int v = 0; v < 6; v++) begin
      qA.push_back('{port: vecs[v].port, rdata: vecs[v].data, tmo: 1'b0});
      applyStimulus(1'b0, vecs[v].port, vecs[v].addr, vecs[v].data, vecs[v].busyCyc, vecs[v].expLat);
      repeat (2) @(negedge clk);
    end

    // Page miss: busy for 1000 cycles, enable must stay up.
    doReset();
    enA = 1'b1;
    qA.push_back('{port: 1'b0, rdata: 8'h3c, tmo: 1'b0});
    @(negedge clk);
    addr0 = 24'h00beef;
    req0 = 1'b1;
    sd_busy = 1'b1;
    sd_data = 8'h00;
    enableDrops = 0;
    @(negedge clk);
    for (int i = 0; i < 999; i++) begin
      @(negedge clk);
      if (sdEnableA !== 1'b1 || sdAddrA !== 24'h00beef) enableDrops++;
    end
    checkOutput("missEnableHeld", 32'(enableDrops), 32'd0);
    sd_busy = 1'b0;
    sd_data = 8'h3c;
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      @(negedge clk);
      if (ackA0 | ackA1) n = 1;
    end
    checkOutput("missAckSeen", 32'(n), 32'd1);
    req0 = 1'b0;
    repeat (10) @(negedge clk);

    // Round-robin tie: both held for three grants -> 0, 1, 0, spaced 5 apart.
    doReset();
    enA = 1'b1;
    for (int i = 0; i < 3; i++) qA.push_back('{port: bit'(i % 2), rdata: 8'h99, tmo: 1'b0});
    @(negedge clk);
    addr0 = 24'h000100;
    addr1 = 24'h000200;
    sd_data = 8'h99;
    req0 = 1'b1;
    req1 = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 3; i++) begin
      @(negedge clk);
      if (ackA0 | ackA1) begin acks[n] = cyc; n++; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("tieAckCount", 32'(n), 32'd3);
    if (n == 3) begin
      checkOutput("tieSpacing1", 32'(acks[1] - acks[0]), 32'd5);
      checkOutput("tieSpacing2", 32'(acks[2] - acks[1]), 32'd5);
    end
    repeat (10) @(negedge clk);

    // Reset mid-WAIT aborts silently; a later req1 is served normally.
    doReset();
    enA = 1'b1;
    @(negedge clk);
    addr0 = 24'h00aaaa;
    req0 = 1'b1;
    sd_busy = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    checkOutput("abortSdEnable", 32'(sdEnableA), 32'd0);
    checkOutput("abortAck", 32'({ackA0, ackA1}), 32'd0);
    checkOutput("abortTimeoutErr", 32'(timeoutA), 32'd0);
    reset = 1'b1;
    sd_busy = 1'b0;
    repeat (5) @(negedge clk);
    qA.push_back('{port: 1'b1, rdata: 8'h6e, tmo: 1'b0});
    applyStimulus(1'b0, 1'b1, 24'h0055aa, 8'h6e, 0, 4);
    repeat (3) @(negedge clk);

    // Fixed priority on B: port 0 served repeatedly, port 1 after req0 drops.
    doReset();
    enB = 1'b1;
    for (int i = 0; i < 3; i++) qB.push_back('{port: 1'b0, rdata: 8'h42, tmo: 1'b0});
    qB.push_back('{port: 1'b1, rdata: 8'h42, tmo: 1'b0});
    @(negedge clk);
    addr0 = 24'h000010;
    addr1 = 24'h000020;
    sd_data = 8'h42;
    req0 = 1'b1;
    req1 = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (ackB0 | ackB1) begin
        n++;
        if (n == 3) req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("fixedAckCount", 32'(n), 32'd4);
    repeat (10) @(negedge clk);

    // Timeout on B: busy stuck, ack after 16 busy WAIT cycles, sticky error.
    doReset();
    enB = 1'b1;
    qB.push_back('{port: 1'b1, rdata: 8'hff, tmo: 1'b1});
    applyStimulus(1'b1, 1'b1, 24'h0abcde, 8'h12, 100000, 19);
    repeat (5) @(negedge clk);
    checkOutput("timeoutSticky", 32'(timeoutB), 32'd1);
    checkOutput("timeoutEnableOff", 32'(sdEnableB), 32'd0);
    doReset();
    @(negedge clk);
    checkOutput("timeoutClearedByReset", 32'(timeoutB), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sd_rom_arbiter.md
SD_ROM_ARBITER -- requirements
Module: sd_rom_arbiter

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 2: cycles between driving a new sd_address and the first sampling of sd_busy (legal range 1..15).
REQ-002 SHALL provide parameter PRIORITY_MODE, default 0: 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 24'd12000000: maximum cycles spent in WAIT before a forced completion.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-006 req0  input  1  port 0 read request; held high until ack0.
REQ-007 addr0  input  24  port 0 byte address; stable while req0 is high.
REQ-008 ack0  output  1  single-cycle completion pulse for port 0.
REQ-009 req1  input  1  port 1 read request; same rules as req0.
REQ-010 addr1  input  24  port 1 byte address.
REQ-011 ack1  output  1  single-cycle completion pulse for port 1.
REQ-012 rdata  output  8  shared read data; valid in the ack cycle and held until the next ack.
REQ-013 sd_address  output  24  address to the paged SD ROM.
REQ-014 sd_enable  output  1  enable to the paged SD ROM.
REQ-015 sd_busy  input  1  registered busy from the paged SD ROM.
REQ-016 sd_data  input  8  registered data from the paged SD ROM.
REQ-017 timeout_err  output  1  sticky flag set on any forced completion.

Function
REQ-018 The block SHALL implement the states IDLE, SETTLE and WAIT.
REQ-019 IDLE: if any req is high at cycle N, the block SHALL select the winner, register its address into sd_address, set sd_enable=1, load the settle counter with SETTLE_CYCLES, and enter SETTLE at N+1.
REQ-020 IDLE with no request: sd_enable SHALL be 0 and sd_address SHALL hold its last value.
REQ-021 SETTLE: the block SHALL decrement the settle counter each cycle and enter WAIT when the counter reaches 0; sd_busy SHALL be ignored while in SETTLE.
REQ-022 WAIT, sd_busy=0: the block SHALL register rdata<=sd_data, pulse the winner's ack for exactly 1 cycle, and return to IDLE.
REQ-023 The hit latency SHALL be as follows: req sampled at cycle N, ack high at cycle N+SETTLE_CYCLES+2 (N+4 at the default).
REQ-024 WAIT, sd_busy=1: the block SHALL keep sd_enable=1 and the address stable, and increment a 24-bit wait counter that is cleared on entry to WAIT.
REQ-025 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL set rdata=8'hff, pulse ack, set timeout_err=1, and return to IDLE.
REQ-026 Round-robin mode: with both requests high in IDLE, the block SHALL grant the port not granted last; a single request SHALL always be granted.
REQ-027 Round-robin mode: a last_grant register SHALL update on each grant.
REQ-028 Fixed mode: port 0 SHALL win whenever req0=1.
REQ-029 At most one ack SHALL be high in any cycle; ack0 and ack1 SHALL never both be 1.
REQ-030 A request arriving while the block is not in IDLE SHALL wait; it SHALL not be dropped and SHALL be evaluated on the next IDLE cycle.
REQ-031 A request that drops before its ack is a protocol violation; the transaction SHALL still complete and its ack SHALL still pulse.
REQ-032 The requester SHALL treat rdata in the ack cycle as final.
REQ-033 The minimum spacing between consecutive grants SHALL be SETTLE_CYCLES+3 cycles, including the IDLE re-arbitration cycle.

Reset
REQ-034 On reset=0 at a clock edge, the block SHALL set state=IDLE, sd_enable=0, sd_address=0, ack0=ack1=0, rdata=0, timeout_err=0, last_grant=port 1 (so port 0 wins the first tie), and clear both counters.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction without an ack; the requester must re-request after reset releases.

Verification
REQ-036 Page hit: req0 with addr0=24'h00c010, sd_busy=0, sd_data=8'h5a -> ack0 at N+4, rdata=8'h5a, sd_address=24'h00c010.
REQ-037 Page miss: sd_busy held 1 for 1000 cycles, then 0 with sd_data=8'h3c -> sd_enable stays 1 throughout, a single ack0 follows, rdata=8'h3c, timeout_err=0.
REQ-038 Tie, round-robin: req0 and req1 both held for 3 transactions -> grant order is 0, 1, 0 with acks spaced 5 cycles apart at defaults; no cycle has both acks high.
REQ-039 Fixed priority, PRIORITY_MODE=1: req0 and req1 both held -> port 0 is served repeatedly; port 1 is served only after req0 drops.
REQ-040 Timeout, TIMEOUT_CYCLES=16: sd_busy stuck at 1 -> ack at wait count 16, rdata=8'hff, timeout_err=1 and sticky until reset.
REQ-041 Reset mid-WAIT: reset=0 for 1 cycle -> next cycle sd_enable=0, no ack, timeout_err=0, and a subsequent req1 is served normally.
